demorgan_exerciser: RTL



---
 rtl/demorgan_pkg.sv | 26 ++
 rtl/demorgan_expect.sv | 20 ++
 rtl/demorgan_exerciser.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/demorgan_pkg.sv
// ============================================================================
// Module  : demorgan_pkg
// Brief   : Shared types, constants and expected-word helper for the exerciser
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package demorgan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } exer_state_t;

  localparam int NUM_VEC = 4;

  // Word order: {nA, nB, nAandB, nAornB, nAorB, nAandnB}
  function automatic logic [5:0] exp_word(input logic a, input logic b);
    return {~a, ~b, ~(a & b), ~a | ~b, ~(a | b), ~a & ~b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/demorgan_expect.sv
// ============================================================================
// Module  : demorgan_expect
// Brief   : Combinational expected-word model for the De Morgan gate block
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demorgan_expect
  import demorgan_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [5:0] expWord
);

  assign expWord = exp_word(a, b);

endmodule

`default_nettype wire

// File: rtl/demorgan_exerciser.sv
// ============================================================================
// Module  : demorgan_exerciser
// Brief   : Sweeps A/B over all four vectors, checks the gate block's six
//           outputs and reports a mismatch count and verdict.
//           Optional first-failure capture: DEMORGAN_EXER_CAPTURE_EN
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demorgan_exerciser
  import demorgan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             A,
  output logic             B,
  input  logic             nA,
  input  logic             nB,
  input  logic             nAandB,
  input  logic             nAornB,
  input  logic             nAorB,
  input  logic             nAandnB,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
`ifdef DEMORGAN_EXER_CAPTURE_EN
  ,
  output logic             fail_valid,
  output logic [1:0]       fail_vec,
  output logic [5:0]       fail_obs
`endif
);

  localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int c_PASS_W   = $clog2(PASSES + 1);

  localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [c_PASS_W-1:0]   c_PASS_LAST   = c_PASS_W'(PASSES - 1);
  localparam logic [ERR_W-1:0]      c_ERR_MAX     = '1;
  localparam logic [1:0]            c_VEC_LAST    = 2'(NUM_VEC - 1);

  exer_state_t             r_state;
  logic [c_SETTLE_W-1:0]   r_settleCnt;
  logic [c_PASS_W-1:0]     r_passCnt;

  logic [5:0]              w_obsWord;
  logic [5:0]              w_expWord;
  logic                    w_mismatch;
  logic [ERR_W-1:0]        w_errNext;
  logic [1:0]              w_vecNext;

  demorgan_expect u_expect (
    .a       (A),
    .b       (B),
    .expWord (w_expWord)
  );

  assign w_obsWord  = {nA, nB, nAandB, nAornB, nAorB, nAandnB};
  assign w_mismatch = (w_obsWord != w_expWord);
  assign w_errNext  = (w_mismatch && (err_count != c_ERR_MAX)) ? err_count + 1'b1 : err_count;
  assign w_vecNext  = vec_idx + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_settleCnt <= '0;
      r_passCnt   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      A           <= 1'b0;
      B           <= 1'b0;
      err_count   <= '0;
      vec_idx     <= 2'd0;
`ifdef DEMORGAN_EXER_CAPTURE_EN
      fail_valid  <= 1'b0;
      fail_vec    <= 2'd0;
      fail_obs    <= 6'd0;
`endif
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= DRIVE;
            r_settleCnt <= '0;
            r_passCnt   <= '0;
            busy        <= 1'b1;
            pass        <= 1'b0;
            err_count   <= '0;
            vec_idx     <= 2'd0;
            A           <= 1'b0;
            B           <= 1'b0;
`ifdef DEMORGAN_EXER_CAPTURE_EN
            fail_valid  <= 1'b0;
            fail_vec    <= 2'd0;
            fail_obs    <= 6'd0;
`endif
          end
        end
        DRIVE: begin
          if (r_settleCnt == c_SETTLE_LAST) begin
            r_state <= SAMPLE;
          end else begin
            r_settleCnt <= r_settleCnt + 1'b1;
          end
        end
        SAMPLE: begin
          err_count   <= w_errNext;
          r_settleCnt <= '0;
`ifdef DEMORGAN_EXER_CAPTURE_EN
          // Only the first mismatch of a run is latched
          if (w_mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= vec_idx;
            fail_obs   <= w_obsWord;
          end
`endif
          if (vec_idx != c_VEC_LAST) begin
            vec_idx <= w_vecNext;
            {A, B}  <= w_vecNext;
            r_state <= DRIVE;
          end else if (r_passCnt != c_PASS_LAST) begin
            vec_idx   <= 2'd0;
            {A, B}    <= 2'd0;
            r_passCnt <= r_passCnt + 1'b1;
            r_state   <= DRIVE;
          end else begin
            // Verdict includes the sample being taken on this edge
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (w_errNext == '0);
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
